// File: rtl/cd_config_arbiter_pkg.sv
// rtl/cd_config_arbiter_pkg.sv - shared types and constants for the clock divider config arbiter
// Purpose: controller state encoding, divider register addresses and boot write count.
// Ports: none (package cd_cfg_pkg).
package cd_cfg_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // Clock divider register map
  localparam int ADDR_VGA  = 0;
  localparam int ADDR_UART = 1;
  localparam int ADDR_LM   = 2;
  localparam int ADDR_DB   = 3;

  // Number of default-divisor writes issued after reset
  localparam int BOOT_COUNT = 4;

endpackage

// File: rtl/cd_config_arbiter_if.sv
// rtl/cd_config_arbiter_if.sv - requester and divider config channels of the arbiter
// Purpose: bundles both upstream write channels, the downstream divider write
//          channel and the status outputs.
// Ports (master = arbiter side):
//   r0_addr/r0_data/r0_valid in, r0_ready out : requester 0 (UART command decoder)
//   r1_addr/r1_data/r1_valid in, r1_ready out : requester 1 (debug host)
//   c_addr/c_data/c_valid out, c_ready in     : registered write to the clock divider
//   gnt out (one-hot owner), boot_done out
interface cd_config_arbiter_if #(
  parameter int WIDTH_CONFIG_ADDR = 2,
  parameter int WIDTH_CONFIG_DATA = 16
);

  logic [WIDTH_CONFIG_ADDR-1:0] r0_addr;
  logic [WIDTH_CONFIG_DATA-1:0] r0_data;
  logic                         r0_valid;
  logic                         r0_ready;

  logic [WIDTH_CONFIG_ADDR-1:0] r1_addr;
  logic [WIDTH_CONFIG_DATA-1:0] r1_data;
  logic                         r1_valid;
  logic                         r1_ready;

  logic [WIDTH_CONFIG_ADDR-1:0] c_addr;
  logic [WIDTH_CONFIG_DATA-1:0] c_data;
  logic                         c_valid;
  logic                         c_ready;

  logic [1:0]                   gnt;
  logic                         boot_done;

  modport master (
    input  r0_addr, r0_data, r0_valid,
    input  r1_addr, r1_data, r1_valid,
    input  c_ready,
    output r0_ready, r1_ready,
    output c_addr, c_data, c_valid,
    output gnt, boot_done
  );

  modport slave (
    output r0_addr, r0_data, r0_valid,
    output r1_addr, r1_data, r1_valid,
    output c_ready,
    input  r0_ready, r1_ready,
    input  c_addr, c_data, c_valid,
    input  gnt, boot_done
  );

endinterface

// File: rtl/cd_config_arbiter_rr.sv
// rtl/cd_config_arbiter_rr.sv - 2-way round-robin picker for the config arbiter
// Purpose: picks one of two requesters; on a tie the one not granted last wins.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_i[1:0]    : requester valids (bit0 = r0, bit1 = r1)
//   update_i      : a granted transfer completed this cycle
//   owner_i[1:0]  : one-hot owner of the completing transfer
//   win_o[1:0]    : one-hot winner (0 when nobody requests)
module cd_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic [1:0] owner_i,
  output logic [1:0] win_o
);

  // 1 = r1 was granted last; resets to r1 so r0 wins the first tie
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (update_i) begin
      last_d = owner_i[1];
    end
  end

  always_comb begin
    win_o = 2'b00;
    case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11:   win_o = last_q ? 2'b01 : 2'b10;
      default: win_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cd_config_arbiter.sv
// rtl/cd_config_arbiter.sv - shares the clock divider config port between two requesters
// Purpose: round-robin arbitration of r0/r1 writes onto the divider's single
//          valid/ready config port; optional boot sequence loading default divisors.
// Ports:
//   clk   : clock, all logic on its rising edge
//   rst_n : asynchronous active-low reset
//   cfg   : cd_config_arbiter_if.master (requester channels, divider channel, gnt, boot_done)
// Build option: CD_BOOT_INIT_EN compiles in the BOOT state, its index counter and
//               the DEF_DIV_* write sequence; without it boot_done is tied high.
module cd_config_arbiter
  import cd_cfg_pkg::*;
#(
  parameter int WIDTH_CONFIG_ADDR = 2,
  parameter int WIDTH_CONFIG_DATA = 16,
  parameter int DEF_DIV_VGA       = 2,
  parameter int DEF_DIV_UART      = 434,
  parameter int DEF_DIV_LM        = 50000,
  parameter int DEF_DIV_DB        = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  cd_config_arbiter_if.master cfg
);

  state_t                       state_q, state_d;
  logic [WIDTH_CONFIG_ADDR-1:0] c_addr_q, c_addr_d;
  logic [WIDTH_CONFIG_DATA-1:0] c_data_q, c_data_d;
  logic                         c_valid_q, c_valid_d;
  logic [1:0]                   gnt_q, gnt_d;
  logic [1:0]                   win;
  logic                         xfer_done;

  assign xfer_done = (state_q == ST_XFER) && c_valid_q && cfg.c_ready;

  cd_rr_arbiter u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({cfg.r1_valid, cfg.r0_valid}),
    .update_i (xfer_done),
    .owner_i  (gnt_q),
    .win_o    (win)
  );

`ifdef CD_BOOT_INIT_EN
  localparam state_t RESET_STATE = ST_BOOT;

  logic [1:0] boot_idx_q, boot_idx_d;
  logic       boot_done_q, boot_done_d;

  function automatic logic [WIDTH_CONFIG_ADDR-1:0] boot_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    boot_addr = WIDTH_CONFIG_ADDR'(ADDR_VGA);
      2'd1:    boot_addr = WIDTH_CONFIG_ADDR'(ADDR_UART);
      2'd2:    boot_addr = WIDTH_CONFIG_ADDR'(ADDR_LM);
      default: boot_addr = WIDTH_CONFIG_ADDR'(ADDR_DB);
    endcase
  endfunction

  // DB divisor does not fit the data bus; its low bits are what the divider gets
  function automatic logic [WIDTH_CONFIG_DATA-1:0] boot_data(input logic [1:0] idx);
    case (idx)
      2'd0:    boot_data = WIDTH_CONFIG_DATA'(DEF_DIV_VGA);
      2'd1:    boot_data = WIDTH_CONFIG_DATA'(DEF_DIV_UART);
      2'd2:    boot_data = WIDTH_CONFIG_DATA'(DEF_DIV_LM);
      default: boot_data = WIDTH_CONFIG_DATA'(DEF_DIV_DB);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_idx_q  <= 2'd0;
      boot_done_q <= 1'b0;
    end else begin
      boot_idx_q  <= boot_idx_d;
      boot_done_q <= boot_done_d;
    end
  end

  assign cfg.boot_done = boot_done_q;
`else
  localparam state_t RESET_STATE = ST_IDLE;

  // Boot constants are only consumed when the boot sequence is built in
  logic unused_boot_cfg;
  assign unused_boot_cfg = ^{DEF_DIV_VGA, DEF_DIV_UART, DEF_DIV_LM, DEF_DIV_DB,
                             ADDR_VGA, ADDR_UART, ADDR_LM, ADDR_DB, BOOT_COUNT};

  assign cfg.boot_done = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    c_addr_d  = c_addr_q;
    c_data_d  = c_data_q;
    c_valid_d = c_valid_q;
    gnt_d     = gnt_q;
`ifdef CD_BOOT_INIT_EN
    boot_idx_d  = boot_idx_q;
    boot_done_d = boot_done_q;
`endif
    case (state_q)
`ifdef CD_BOOT_INIT_EN
      ST_BOOT: begin
        if (!c_valid_q) begin
          // First cycle after reset: present the pair for the current index
          c_addr_d  = boot_addr(boot_idx_q);
          c_data_d  = boot_data(boot_idx_q);
          c_valid_d = 1'b1;
        end else if (cfg.c_ready) begin
          if (boot_idx_q == 2'(BOOT_COUNT - 1)) begin
            c_valid_d   = 1'b0;
            boot_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            // Next pair loads on the same edge as the handshake
            boot_idx_d = boot_idx_q + 2'd1;
            c_addr_d   = boot_addr(boot_idx_q + 2'd1);
            c_data_d   = boot_data(boot_idx_q + 2'd1);
          end
        end
      end
`endif
      ST_IDLE: begin
        if (|win) begin
          c_addr_d  = win[0] ? cfg.r0_addr : cfg.r1_addr;
          c_data_d  = win[0] ? cfg.r0_data : cfg.r1_data;
          c_valid_d = 1'b1;
          gnt_d     = win;
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        // Latched write completes regardless of the owner's valid
        if (cfg.c_ready) begin
          c_valid_d = 1'b0;
          gnt_d     = 2'b00;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      c_addr_q  <= '0;
      c_data_q  <= '0;
      c_valid_q <= 1'b0;
      gnt_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      c_addr_q  <= c_addr_d;
      c_data_q  <= c_data_d;
      c_valid_q <= c_valid_d;
      gnt_q     <= gnt_d;
    end
  end

  assign cfg.c_addr  = c_addr_q;
  assign cfg.c_data  = c_data_q;
  assign cfg.c_valid = c_valid_q;
  assign cfg.gnt     = gnt_q;

  // Upstream ready mirrors the downstream handshake of the current owner
  assign cfg.r0_ready = gnt_q[0] && cfg.c_ready;
  assign cfg.r1_ready = gnt_q[1] && cfg.c_ready;

endmodule

// File: tb/tb_cd_config_arbiter.sv
// tb/tb_cd_config_arbiter.sv - self-checking bench for cd_config_arbiter
module tb_cd_config_arbiter;

  localparam int WA = 2;
  localparam int WD = 16;

`ifdef CD_BOOT_INIT_EN
  localparam logic EXP_BOOT_RST = 1'b0;
`else
  localparam logic EXP_BOOT_RST = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cd_config_arbiter_if #(.WIDTH_CONFIG_ADDR(WA), .WIDTH_CONFIG_DATA(WD)) bus ();

  cd_config_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        v0;
    logic [1:0]  a0;
    logic [15:0] d0;
    logic        v1;
    logic [1:0]  a1;
    logic [15:0] d1;
    logic        cr;
    logic        e_cv;
    logic [1:0]  e_a;
    logic [15:0] e_d;
    logic [1:0]  e_g;
    logic        e_r0;
    logic        e_r1;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [1:0] a0, input logic [15:0] d0,
                       input logic v1, input logic [1:0] a1, input logic [15:0] d1,
                       input logic cr);
    bus.r0_valid = v0; bus.r0_addr = a0; bus.r0_data = d0;
    bus.r1_valid = v1; bus.r1_addr = a1; bus.r1_data = d1;
    bus.c_ready  = cr;
  endtask

  // Address/data are only meaningful while a write is offered
  task automatic chk_out(input string tag, input logic e_cv, input logic [1:0] e_a,
                         input logic [15:0] e_d, input logic [1:0] e_g,
                         input logic e_r0, input logic e_r1);
    chk({tag, ".c_valid"},  32'(bus.c_valid),  32'(e_cv));
    chk({tag, ".gnt"},      32'(bus.gnt),      32'(e_g));
    chk({tag, ".r0_ready"}, 32'(bus.r0_ready), 32'(e_r0));
    chk({tag, ".r1_ready"}, 32'(bus.r1_ready), 32'(e_r1));
    if (e_cv) begin
      chk({tag, ".c_addr"}, 32'(bus.c_addr), 32'(e_a));
      chk({tag, ".c_data"}, 32'(bus.c_data), 32'(e_d));
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    @(negedge clk);
    chk("rst.c_valid",   32'(bus.c_valid),   32'd0);
    chk("rst.c_addr",    32'(bus.c_addr),    32'd0);
    chk("rst.c_data",    32'(bus.c_data),    32'd0);
    chk("rst.gnt",       32'(bus.gnt),       32'd0);
    chk("rst.r0_ready",  32'(bus.r0_ready),  32'd0);
    chk("rst.r1_ready",  32'(bus.r1_ready),  32'd0);
    chk("rst.boot_done", 32'(bus.boot_done), 32'(EXP_BOOT_RST));
    next_cycle();
    rst_n = 1'b1;
  endtask

`ifdef CD_BOOT_INIT_EN
  // Starts at cycle 0 after reset release; optional stall on one index and an r0
  // request held throughout the boot.
  task automatic boot_seq(input int stall_idx, input int stall_n, input logic hold_r0);
    logic [15:0] bd[4];
    bd[0] = 16'd2; bd[1] = 16'd434; bd[2] = 16'd50000; bd[3] = 16'hA120;
    drive(hold_r0, 2'd2, 16'h0ABC, 1'b0, 2'd0, 16'h0, 1'b1);
    @(negedge clk);
    chk("boot0.c_valid",   32'(bus.c_valid),   32'd0);
    chk("boot0.boot_done", 32'(bus.boot_done), 32'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s <= stall_n; s++) begin
        bus.c_ready = (i == stall_idx && s < stall_n) ? 1'b0 : 1'b1;
        @(negedge clk);
        chk_out($sformatf("boot_w%0d", i), 1'b1, 2'(i), bd[i], 2'b00, 1'b0, 1'b0);
        chk("boot.boot_done", 32'(bus.boot_done), 32'd0);
        next_cycle();
        if (bus.c_ready) break;
      end
    end
    bus.c_ready = 1'b0;
    @(negedge clk);
    chk_out("boot_idle", 1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("boot_end.boot_done", 32'(bus.boot_done), 32'd1);
    next_cycle();
    if (hold_r0) begin
      @(negedge clk);
      chk_out("boot_r0_wait", 1'b1, 2'd2, 16'h0ABC, 2'b01, 1'b0, 1'b0);
      bus.c_ready = 1'b1;
      #1;
      chk_out("boot_r0_hs", 1'b1, 2'd2, 16'h0ABC, 2'b01, 1'b1, 1'b0);
      next_cycle();
      drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
      next_cycle();
    end
  endtask
`endif

  task automatic post_reset();
`ifdef CD_BOOT_INIT_EN
    boot_seq(-1, 0, 1'b0);
`endif
  endtask

  // Reference model state: whether a write is in flight, who owns it, who went last
  bit          m_busy;
  int          m_owner;
  int          m_last;
  logic [1:0]  m_addr;
  logic [15:0] m_data;

  initial begin
    logic        rv0, rv1, cr, hs0, hs1, e_r0, e_r1;
    logic [1:0]  ra0, ra1, e_g;
    logic [15:0] rd0, rd1;

    vt[0]  = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0, 1'b0,2'd0,16'h0000,2'b00,1'b0,1'b0};
    vt[1]  = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b1, 1'b0,2'd0,16'h0000,2'b00,1'b0,1'b0};
    vt[2]  = '{1'b1,2'd1,16'h1111, 1'b1,2'd2,16'h2222, 1'b0, 1'b0,2'd0,16'h0000,2'b00,1'b0,1'b0};
    vt[3]  = '{1'b1,2'd1,16'h1111, 1'b1,2'd2,16'h2222, 1'b0, 1'b1,2'd1,16'h1111,2'b01,1'b0,1'b0};
    vt[4]  = '{1'b1,2'd1,16'h1111, 1'b1,2'd2,16'h2222, 1'b1, 1'b1,2'd1,16'h1111,2'b01,1'b1,1'b0};
    vt[5]  = '{1'b1,2'd3,16'h3333, 1'b1,2'd2,16'h2222, 1'b1, 1'b0,2'd0,16'h0000,2'b00,1'b0,1'b0};
    vt[6]  = '{1'b1,2'd3,16'h3333, 1'b1,2'd2,16'h2222, 1'b1, 1'b1,2'd2,16'h2222,2'b10,1'b0,1'b1};
    vt[7]  = '{1'b1,2'd3,16'h3333, 1'b0,2'd0,16'h0000, 1'b0, 1'b0,2'd0,16'h0000,2'b00,1'b0,1'b0};
    vt[8]  = '{1'b0,2'd3,16'h3333, 1'b0,2'd0,16'h0000, 1'b0, 1'b1,2'd3,16'h3333,2'b01,1'b0,1'b0};
    vt[9]  = '{1'b0,2'd3,16'h3333, 1'b0,2'd0,16'h0000, 1'b1, 1'b1,2'd3,16'h3333,2'b01,1'b1,1'b0};
    vt[10] = '{1'b0,2'd0,16'h0000, 1'b1,2'd0,16'hBEEF, 1'b1, 1'b0,2'd0,16'h0000,2'b00,1'b0,1'b0};
    vt[11] = '{1'b0,2'd0,16'h0000, 1'b1,2'd0,16'hBEEF, 1'b0, 1'b1,2'd0,16'hBEEF,2'b10,1'b0,1'b0};
    vt[12] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'hBEEF, 1'b1, 1'b1,2'd0,16'hBEEF,2'b10,1'b0,1'b1};
    vt[13] = '{1'b0,2'd0,16'h0000, 1'b0,2'd0,16'h0000, 1'b0, 1'b0,2'd0,16'h0000,2'b00,1'b0,1'b0};

    // Reset state, then the vector table starting in IDLE with r1 as last owner
    do_reset();
    post_reset();
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].v0, vt[i].a0, vt[i].d0, vt[i].v1, vt[i].a1, vt[i].d1, vt[i].cr);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vt[i].e_cv, vt[i].e_a, vt[i].e_d,
              vt[i].e_g, vt[i].e_r0, vt[i].e_r1);
      next_cycle();
    end

    // Only r1 requests; divider stalls 5 cycles
    drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 16'h1234, 1'b0);
    @(negedge clk);
    chk_out("r1s_idle", 1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 1'b0);
    next_cycle();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk_out($sformatf("r1s_stall%0d", s), 1'b1, 2'd2, 16'h1234, 2'b10, 1'b0, 1'b0);
      next_cycle();
    end
    bus.c_ready = 1'b1;
    @(negedge clk);
    chk_out("r1s_hs", 1'b1, 2'd2, 16'h1234, 2'b10, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    @(negedge clk);
    chk_out("r1s_after", 1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 1'b0);
    next_cycle();

    // Both requesters continuously valid: r0,r1,r0,r1 every other cycle
    drive(1'b1, 2'd1, 16'hA0A0, 1'b1, 2'd2, 16'hB1B1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk_out($sformatf("alt%0d_idle", k), 1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 1'b0);
      end else if ((k / 2) % 2 == 0) begin
        chk_out($sformatf("alt%0d_r0", k), 1'b1, 2'd1, 16'hA0A0, 2'b01, 1'b1, 1'b0);
      end else begin
        chk_out($sformatf("alt%0d_r1", k), 1'b1, 2'd2, 16'hB1B1, 2'b10, 1'b0, 1'b1);
      end
      next_cycle();
    end

    // Randomized traffic against the reference model
    do_reset();
    post_reset();
    m_busy = 1'b0; m_owner = 0; m_last = 1; m_addr = '0; m_data = '0;
    rv0 = 1'b0; rv1 = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
    ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!rv0 || hs0) begin
        rv0 = ($urandom_range(0, 2) != 0); ra0 = 2'($urandom); rd0 = 16'($urandom);
      end
      if (!rv1 || hs1) begin
        rv1 = ($urandom_range(0, 2) != 0); ra1 = 2'($urandom); rd1 = 16'($urandom);
      end
      cr = ($urandom_range(0, 3) != 0);
      drive(rv0, ra0, rd0, rv1, ra1, rd1, cr);
      e_g  = !m_busy ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
      e_r0 = m_busy && m_owner == 0 && cr;
      e_r1 = m_busy && m_owner == 1 && cr;
      @(negedge clk);
      chk_out("rand", m_busy, m_addr, m_data, e_g, e_r0, e_r1);
      hs0 = rv0 && e_r0;
      hs1 = rv1 && e_r1;
      if (m_busy) begin
        if (cr) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end else if (rv0 || rv1) begin
        m_owner = (rv0 && rv1) ? 1 - m_last : (rv0 ? 0 : 1);
        m_busy  = 1'b1;
        m_addr  = (m_owner == 0) ? ra0 : ra1;
        m_data  = (m_owner == 0) ? rd0 : rd1;
      end
      next_cycle();
    end

`ifdef CD_BOOT_INIT_EN
    // Boot with index 1 stalled 3 cycles while r0 waits
    do_reset();
    boot_seq(1, 3, 1'b1);
`endif

    // Asynchronous reset in the middle of a transfer
    drive(1'b1, 2'd1, 16'h5A5A, 1'b0, 2'd0, 16'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_out("arst_pre", 1'b1, 2'd1, 16'h5A5A, 2'b01, 1'b0, 1'b0);
    #1;
    bus.c_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_out("arst_now", 1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 1'b0);
    do_reset();
    post_reset();

    // First request after reset reaches c_valid one cycle after being sampled
    drive(1'b1, 2'd2, 16'h0F0F, 1'b0, 2'd0, 16'h0, 1'b0);
    @(negedge clk);
    chk_out("lat_idle", 1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("lat.boot_done", 32'(bus.boot_done), 32'd1);
    next_cycle();
    @(negedge clk);
    chk_out("lat_xfer", 1'b1, 2'd2, 16'h0F0F, 2'b01, 1'b0, 1'b0);
    bus.c_ready = 1'b1;
    #1;
    chk_out("lat_hs", 1'b1, 2'd2, 16'h0F0F, 2'b01, 1'b1, 1'b0);
    next_cycle();
    drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    @(negedge clk);
    chk_out("lat_done", 1'b0, 2'd0, 16'h0, 2'b00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cd_config_arbiter.md
# cd_config_arbiter

Configuration-port controller for the clock divider. Shares the divider's single valid/ready config port (`c_addr`/`c_data`/`c_valid`/`c_ready`) between two upstream requesters (r0: UART command decoder, r1: debug host) with round-robin fairness. Optionally runs a boot sequence after reset that loads default divisors for the VGA, UART, LM and DB clocks before any requester is served. Sits between the requesters and the clock divider's config inputs.

## Interface
Parameters:
- `WIDTH_CONFIG_ADDR`, 2, config address width, same value as the clock divider's.
- `WIDTH_CONFIG_DATA`, 16, config data width, same value as the clock divider's.
- `DEF_DIV_VGA`, 2, boot divisor written to the VGA register.
- `DEF_DIV_UART`, 434, boot divisor written to the UART register.
- `DEF_DIV_LM`, 50000, boot divisor written to the LM register.
- `DEF_DIV_DB`, 500000, boot divisor, truncated to `WIDTH_CONFIG_DATA`.

Ports:
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `r0_addr` in `WIDTH_CONFIG_ADDR`, `r0_data` in `WIDTH_CONFIG_DATA`, `r0_valid` in 1, `r0_ready` out 1: requester 0 write channel.
- `r1_addr`, `r1_data`, `r1_valid`, `r1_ready`: requester 1 write channel, same widths.
- `c_addr` out `WIDTH_CONFIG_ADDR`, `c_data` out `WIDTH_CONFIG_DATA`, `c_valid` out 1: registered write to the clock divider.
- `c_ready` in 1: clock divider accepts the write.
- `gnt` out 2: one-hot current owner (bit0 = r0, bit1 = r1); 0 when idle or booting.
- `boot_done` out 1: high once the boot writes are complete; stays high until reset.

## Operation
- States: BOOT (macro only), IDLE, XFER.
- Reset values: `c_valid`=0, `c_addr`=0, `c_data`=0, `gnt`=0, `r0_ready`=`r1_ready`=0, `boot_done`=0 (1 without macro), state BOOT (IDLE without macro), RR pointer = r1 (so r0 wins first tie).
- BOOT: 2-bit index 0..3 selects addresses `ADDR_VGA`=0, `ADDR_UART`=1, `ADDR_LM`=2, `ADDR_DB`=3 with the matching `DEF_DIV_*` value. `c_valid` is held high. On `c_valid&&c_ready` the index increments and the next pair loads on the same edge. After index 3 handshakes: `c_valid`=0, `boot_done`=1, go to IDLE. `r*_ready` stays 0 throughout BOOT.
- IDLE: if any `r*_valid` is high, the winner is chosen as follows. Only one valid: that requester. Both valid: the requester not granted last. The winner's addr/data are latched into `c_addr`/`c_data`, `c_valid`=1, `gnt` is set, and the state goes to XFER.
- XFER: hold `c_addr`/`c_data`/`c_valid` stable until `c_ready`. `rN_ready` = (`gnt[N]` && `c_ready`) is combinational and pulses exactly in the downstream handshake cycle. On handshake: `c_valid`=0, `gnt`=0, update RR pointer, return to IDLE.
- Requesters hold valid/addr/data until their ready. Deassertion of a granted requester's valid during XFER is ignored; the latched write completes.
- A non-granted requester's ready stays 0.

## Timing
- Request sampled in IDLE at edge N gives `c_valid` high after edge N (latency 1).
- Handshake cycle: upstream ready is asserted the same cycle. IDLE occupies the next cycle. Maximum throughput is one external write per 2 cycles.
- Boot with `c_ready` tied high: writes occur in cycles 1–4 after reset release, and `boot_done` rises after the 4th handshake edge.
- `c_ready` high while `c_valid` is low: ignored.
- Asserting `rst_n` mid-transfer immediately drops `c_valid`, `gnt` and the readies. The boot sequence restarts from index 0.

## Configuration
- `CD_BOOT_INIT_EN` defined: the BOOT state, index counter and `DEF_DIV_*` muxing are compiled in. `boot_done` resets to 0.
- `CD_BOOT_INIT_EN` undefined: no BOOT state. Reset goes straight to IDLE, `boot_done` is tied 1, and the divider keeps its own reset values.

## Structure
- Package `cd_cfg_pkg`: state enum (`ST_BOOT`, `ST_IDLE`, `ST_XFER`), address constants `ADDR_VGA/UART/LM/DB`, boot count constant 4.
- Sub-module `cd_rr_arbiter`: 2-way round-robin picker. Inputs are the two valids, the last-grant pointer and an update strobe. Output is a one-hot winner.

## Test plan
- Boot, `c_ready`=1: writes (0,2),(1,434),(2,50000),(3,500000 truncated) on consecutive cycles, then `boot_done`=1. `r0_valid` held during boot gets `r0_ready`=0 until after boot.
- Boot with `c_ready` low 3 cycles on index 1: `c_addr`=1 and `c_data`=434 are held stable, with no index advance.
- After boot, `r0_valid` and `r1_valid` both high continuously: grants alternate r0,r1,r0,r1. Each `rN_ready` pulses for 1 cycle, aligned with `c_ready`.
- Only r1 requests (addr 2, data 0x1234) with `c_ready` delayed 5 cycles: `c_valid` held 5 cycles, `r1_ready` pulses once, `gnt`=2'b10 throughout.
- `rst_n` low mid-XFER: `c_valid`, `gnt` and the readies go 0 asynchronously. After release, boot restarts at address 0.
- Macro undefined: `boot_done`=1 out of reset, and the first `r0` request appears on `c_valid` one cycle after sampling.
